// File: rtl/ghostbus_host_bridge.sv
// ghostbus_host_bridge
//   Host-side initiator for the ghostbus. Byte-wide command frames arrive on
//   the rx stream and each becomes one ghostbus write or read cycle. Read data
//   goes back MSB first on the tx stream.
//   Frame: cmd (0x00 write, 0x80 read), AW/8 address bytes MSB first, then
//   DW/8 data bytes MSB first for writes. Any other cmd byte is consumed and
//   sets the sticky err flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_data/valid/ready command byte stream in
//   tx_data/valid/ready response byte stream out (read data only)
//   gb_addr/gb_dout     registered bus address / write data (hold between cycles)
//   gb_we               one-cycle write strobe
//   gb_din              peripheral read data, valid RD_LAT cycles after gb_addr
//   busy                high whenever the bridge is not idle
//   err                 sticky illegal-command flag, cleared only by reset
module ghostbus_host_bridge #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  input  logic [DW-1:0] gb_din,
  output logic          busy,
  output logic          err
);

  localparam int AB = AW / 8;
  localparam int DB = DW / 8;
  localparam int NB = (AB > DB) ? AB : DB;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0] A_LAST = CW'(AB - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DB - 1);
  localparam logic [3:0]    L_LAST = 4'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WSTB, S_RWAIT, S_RSEND
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lat_q, lat_d;
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic          en_q;
  logic [AW-1:0] addr_sh_q, addr_sh_d;
  logic [DW-1:0] data_sh_q, data_sh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] tx_sh_q, tx_sh_d;
  logic          rx_fire;

  // en_q keeps rx_ready low while reset is held even though state is IDLE.
  assign rx_ready = en_q & ((state_q == S_IDLE) | (state_q == S_ADDR) |
                            (state_q == S_WDATA));
  assign rx_fire  = rx_valid & rx_ready;
  assign tx_valid = (state_q == S_RSEND);
  assign tx_data  = tx_sh_q[DW-1 -: 8];
  assign gb_we    = (state_q == S_WSTB);
  assign gb_addr  = addr_q;
  assign gb_dout  = dout_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lat_q     <= '0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      tx_sh_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      en_q      <= 1'b1;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      tx_sh_q   <= tx_sh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    rd_d      = rd_q;
    err_d     = err_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    tx_sh_d   = tx_sh_q;
    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data == 8'h00 || rx_data == 8'h80) begin
            rd_d    = rx_data[7];
            state_d = S_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_sh_d = (addr_sh_q << 8) | AW'(rx_data);
          if (cnt_q == A_LAST) begin
            addr_d  = addr_sh_d;
            state_d = rd_q ? S_RWAIT : S_WDATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          data_sh_d = (data_sh_q << 8) | DW'(rx_data);
          if (cnt_q == D_LAST) begin
            dout_d  = data_sh_d;
            state_d = S_WSTB;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WSTB: state_d = S_IDLE;
      S_RWAIT: begin
        // gb_addr became valid on entry; gb_din is due RD_LAT edges later.
        if (lat_q == L_LAST) begin
          tx_sh_d = gb_din;
          state_d = S_RSEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_RSEND: begin
        if (tx_ready) begin
          tx_sh_d = tx_sh_q << 8;
          if (cnt_q == D_LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Counters restart on every state entry.
    if (state_d != state_q) begin
      cnt_d = '0;
      lat_d = '0;
    end
  end

endmodule

// File: tb/tb_ghostbus_host_bridge.sv
`timescale 1ns/1ps
module tb_ghostbus_host_bridge;
  localparam int AW = 24;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0] a_rx_data, b_rx_data, a_tx_data, b_tx_data;
  logic a_rx_valid, a_rx_ready, a_tx_valid, a_tx_ready, a_gb_we, a_busy, a_err;
  logic b_rx_valid, b_rx_ready, b_tx_valid, b_tx_ready, b_gb_we, b_busy, b_err;
  logic [AW-1:0] a_gb_addr, b_gb_addr;
  logic [DW-1:0] a_gb_dout, b_gb_dout;
  logic [DW-1:0] a_gb_din = '0;
  logic [DW-1:0] b_gb_din = '0;

  ghostbus_host_bridge #(.AW(AW), .DW(DW), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .rx_ready(a_rx_ready), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .gb_addr(a_gb_addr), .gb_dout(a_gb_dout),
    .gb_we(a_gb_we), .gb_din(a_gb_din), .busy(a_busy), .err(a_err));

  ghostbus_host_bridge #(.AW(AW), .DW(DW), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_ready(b_rx_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .gb_addr(b_gb_addr), .gb_dout(b_gb_dout),
    .gb_we(b_gb_we), .gb_din(b_gb_din), .busy(b_busy), .err(b_err));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Peripheral register contents seen by the bridge.
  function automatic logic [31:0] pdata(input logic [23:0] a);
    if (a == 24'h000004) return 32'h00000042;
    if (a == 24'h000010) return 32'h12345678;
    return {a[7:0], 8'h5A, a[15:8] ^ 8'hC3, a[23:16]};
  endfunction

  // Peripherals: read data is correct only in the one cycle that ends on the
  // edge RD_LAT cycles after gb_addr changed; inverted data otherwise.
  logic [AW-1:0] a_prev = '0, b_prev = '0;
  int a_age = 0, b_age = 0;
  always @(negedge clk) begin
    if (a_gb_addr !== a_prev) begin a_prev = a_gb_addr; a_age = 0; end
    else if (a_age < 1000) a_age++;
    if (b_gb_addr !== b_prev) begin b_prev = b_gb_addr; b_age = 0; end
    else if (b_age < 1000) b_age++;
    a_gb_din = (a_age == 0) ? pdata(a_gb_addr) : ~pdata(a_gb_addr);
    b_gb_din = (b_age == 2) ? pdata(b_gb_addr) : ~pdata(b_gb_addr);
  end

  typedef struct packed {logic [23:0] addr; logic [31:0] data;} wr_t;
  wr_t        a_we_q[$];
  logic [7:0] a_tx_q[$];
  logic [7:0] b_tx_q[$];
  logic       a_rx_fire, b_rx_fire;
  int         a_rdy_mode = 0;
  int         cyc = 0;

  // Advance one clock, logging handshakes/strobes seen just before the edge.
  task automatic step();
    logic pre_we, pre_stall;
    logic [7:0] pre_tx;
    case (a_rdy_mode)
      0:       a_tx_ready = 1'b1;
      1:       a_tx_ready = (cyc % 3 == 0);
      default: a_tx_ready = 1'($urandom_range(0, 1));
    endcase
    b_tx_ready = 1'b1;
    a_rx_fire = a_rx_valid && a_rx_ready;
    b_rx_fire = b_rx_valid && b_rx_ready;
    if (a_tx_valid && a_tx_ready) a_tx_q.push_back(a_tx_data);
    if (b_tx_valid && b_tx_ready) b_tx_q.push_back(b_tx_data);
    if (a_gb_we) a_we_q.push_back({a_gb_addr, a_gb_dout});
    pre_we    = a_gb_we;
    pre_stall = a_tx_valid && !a_tx_ready;
    pre_tx    = a_tx_data;
    @(posedge clk); #1;
    cyc++;
    if (pre_we) chk("we_then_idle", 64'({a_gb_we, a_busy}), 64'd0);
    if (pre_stall) chk("tx_stall_hold", 64'({a_tx_valid, a_tx_data}), 64'({1'b1, pre_tx}));
  endtask

  task automatic send_a(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin a_rx_valid = 1'b0; step(); end
    a_rx_valid = 1'b1;
    a_rx_data  = b;
    n = 0;
    do begin step(); n++; end while (!a_rx_fire && n < 200);
    chk("a_rx_accept", 64'(a_rx_fire), 64'd1);
    a_rx_valid = 1'b0;
  endtask

  task automatic hold_b();
    int n = 0;
    do begin step(); n++; end while (!b_rx_fire && n < 200);
    chk("b_rx_accept", 64'(b_rx_fire), 64'd1);
  endtask

  task automatic send_b(input logic [7:0] b);
    b_rx_valid = 1'b1;
    b_rx_data  = b;
    hold_b();
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (a_busy && n < 500) begin step(); n++; end
    chk("a_idle", 64'(a_busy), 64'd0);
    step();
  endtask

  task automatic frame_a(input logic [7:0] cmd, input logic [23:0] addr,
                         input logic [31:0] data, input int gap);
    send_a(cmd, gap);
    if (cmd == 8'h00 || cmd == 8'h80) begin
      for (int i = 2; i >= 0; i--) send_a(addr[i*8 +: 8], gap);
      if (cmd == 8'h00) for (int i = 3; i >= 0; i--) send_a(data[i*8 +: 8], gap);
    end
    wait_idle_a();
  endtask

  task automatic check_a(input string nm, input int exp_we, input logic [23:0] waddr,
                         input logic [31:0] wdata, input int exp_tx, input logic [31:0] rd,
                         input logic e, input logic [23:0] gaddr, input logic [31:0] gdout);
    logic [31:0] w;
    chk({nm, "_we_cnt"}, 64'(a_we_q.size()), 64'(exp_we));
    if (exp_we == 1 && a_we_q.size() == 1) begin
      chk({nm, "_we_addr"}, 64'(a_we_q[0].addr), 64'(waddr));
      chk({nm, "_we_data"}, 64'(a_we_q[0].data), 64'(wdata));
    end
    chk({nm, "_tx_cnt"}, 64'(a_tx_q.size()), 64'(exp_tx));
    if (exp_tx == 4 && a_tx_q.size() == 4) begin
      w = {a_tx_q[0], a_tx_q[1], a_tx_q[2], a_tx_q[3]};
      chk({nm, "_tx_word"}, 64'(w), 64'(rd));
    end
    chk({nm, "_err"}, 64'(a_err), 64'(e));
    chk({nm, "_gb_addr"}, 64'(a_gb_addr), 64'(gaddr));
    chk({nm, "_gb_dout"}, 64'(a_gb_dout), 64'(gdout));
    chk({nm, "_tx_valid"}, 64'(a_tx_valid), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] data;
    int          exp_we;
    int          exp_tx;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [23:0] exp_addr;
    logic [31:0] exp_dout;
  } vec_t;
  vec_t vt[4];

  task automatic run_table();
    vt[0] = '{8'h00, 24'h000100, 32'hDEADBEEF, 1, 0, 32'h0,        1'b0, 24'h000100, 32'hDEADBEEF};
    vt[1] = '{8'h80, 24'h000004, 32'h0,        0, 4, 32'h00000042, 1'b0, 24'h000004, 32'hDEADBEEF};
    vt[2] = '{8'h41, 24'h0,      32'h0,        0, 0, 32'h0,        1'b1, 24'h000004, 32'hDEADBEEF};
    vt[3] = '{8'h00, 24'h000008, 32'h000004D2, 1, 0, 32'h0,        1'b1, 24'h000008, 32'h000004D2};
    for (int i = 0; i < 4; i++) begin
      a_we_q.delete();
      a_tx_q.delete();
      frame_a(vt[i].cmd, vt[i].addr, vt[i].data, 0);
      check_a($sformatf("vec%0d", i), vt[i].exp_we, vt[i].addr, vt[i].data, vt[i].exp_tx,
              vt[i].exp_rd, vt[i].exp_err, vt[i].exp_addr, vt[i].exp_dout);
    end
  endtask

  task automatic run_stall();
    a_we_q.delete();
    a_tx_q.delete();
    a_rdy_mode = 1;
    frame_a(8'h80, 24'h000010, 32'h0, 0);
    a_rdy_mode = 0;
    check_a("stall", 0, 24'h0, 32'h0, 4, 32'h12345678, 1'b1, 24'h000010, 32'h000004D2);
  endtask

  task automatic run_reset();
    a_we_q.delete();
    a_tx_q.delete();
    send_a(8'h00, 0);
    send_a(8'h00, 0);
    send_a(8'h01, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rx_ready", 64'(a_rx_ready), 64'd0);
    chk("rst_tx_valid", 64'(a_tx_valid), 64'd0);
    chk("rst_tx_data", 64'(a_tx_data), 64'd0);
    chk("rst_gb_addr", 64'(a_gb_addr), 64'd0);
    chk("rst_gb_dout", 64'(a_gb_dout), 64'd0);
    chk("rst_gb_we", 64'(a_gb_we), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    step();
    step();
    chk("rst_rx_ready_held", 64'(a_rx_ready), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_rx_ready_after", 64'(a_rx_ready), 64'd1);
    frame_a(8'h80, 24'h0000AB, 32'h0, 0);
    check_a("post_rst", 0, 24'h0, 32'h0, 4, pdata(24'h0000AB), 1'b0, 24'h0000AB, 32'h0);
  endtask

  task automatic run_lat3();
    logic [23:0] ads[2];
    int bad, n;
    logic [31:0] w;
    ads[0] = 24'h000020;
    ads[1] = 24'h000030;
    b_tx_q.delete();
    for (int f = 0; f < 2; f++) begin
      if (f == 0) send_b(8'h80); else hold_b();
      send_b(ads[f][23:16]);
      send_b(ads[f][15:8]);
      send_b(ads[f][7:0]);
      // Keep rx_valid high: next frame's cmd (or idle for the last frame).
      b_rx_valid = (f == 0);
      b_rx_data  = 8'h80;
      bad = 0;
      n   = 0;
      while (b_tx_q.size() < 4 * (f + 1) && n < 200) begin
        if (b_rx_ready) bad++;
        step();
        n++;
      end
      chk($sformatf("b_rdy_low_f%0d", f), 64'(bad), 64'd0);
    end
    b_rx_valid = 1'b0;
    step();
    chk("b_tx_cnt", 64'(b_tx_q.size()), 64'd8);
    if (b_tx_q.size() == 8) begin
      w = {b_tx_q[0], b_tx_q[1], b_tx_q[2], b_tx_q[3]};
      chk("b_word0", 64'(w), 64'(pdata(24'h000020)));
      w = {b_tx_q[4], b_tx_q[5], b_tx_q[6], b_tx_q[7]};
      chk("b_word1", 64'(w), 64'(pdata(24'h000030)));
    end
    chk("b_we", 64'(b_gb_we), 64'd0);
    chk("b_busy", 64'(b_busy), 64'd0);
  endtask

  task automatic run_random();
    logic [23:0] m_addr = 24'h0000AB;
    logic [31:0] m_dout = 32'h0;
    logic        m_err  = 1'b0;
    logic [7:0]  cmd;
    logic [23:0] ad;
    logic [31:0] dt;
    int sel, gap, exp_we, exp_tx;
    logic [31:0] exp_rd;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      gap = $urandom_range(0, 2);
      a_rdy_mode = $urandom_range(0, 2);
      dt = $urandom;
      do ad = 24'($urandom); while (ad == m_addr);
      if (sel < 4) cmd = 8'h00;
      else if (sel < 8) cmd = 8'h80;
      else begin
        do cmd = 8'($urandom); while (cmd == 8'h00 || cmd == 8'h80);
      end
      a_we_q.delete();
      a_tx_q.delete();
      frame_a(cmd, ad, dt, gap);
      exp_we = 0;
      exp_tx = 0;
      exp_rd = 32'h0;
      if (cmd == 8'h00) begin
        exp_we = 1; m_addr = ad; m_dout = dt;
      end else if (cmd == 8'h80) begin
        exp_tx = 4; exp_rd = pdata(ad); m_addr = ad;
      end else begin
        m_err = 1'b1;
      end
      check_a($sformatf("rnd%0d", k), exp_we, ad, dt, exp_tx, exp_rd, m_err, m_addr, m_dout);
    end
    a_rdy_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    a_rx_valid = 1'b0; a_rx_data = 8'h0; a_tx_ready = 1'b1;
    b_rx_valid = 1'b0; b_rx_data = 8'h0; b_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("init_rx_ready", 64'(a_rx_ready), 64'd0);
    chk("init_outputs", 64'({a_tx_valid, a_tx_data, a_gb_we, a_busy, a_err}), 64'd0);
    chk("init_gb_addr", 64'(a_gb_addr), 64'd0);
    chk("init_gb_dout", 64'(a_gb_dout), 64'd0);
    chk("init_b_busy", 64'({b_busy, b_tx_valid, b_rx_ready}), 64'd0);
    rst_n = 1'b1;
    step();
    chk("init_rx_ready_after", 64'(a_rx_ready), 64'd1);
    run_table();
    run_stall();
    run_reset();
    run_lat3();
    run_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
